regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port integer register file with a built-in scoreboard and a post-reset clear sequencer. It sits between decode (read and allocate) and writeback (write and release) in the core pipeline. Read and write port counts, data width and register count are configurable. It provides same-cycle write-to-read bypass, hardwired-zero register 0, and per-register busy tracking for pending results.

## Interface
- `XLEN`, 32, data width in bits
- `NREGS`, 32, number of architectural registers (power of two, ≥4); `IW = $clog2(NREGS)`
- `NRD`, 2, number of read ports
- `NWR`, 2, number of write ports

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ready_o`  out  1  high once the clear sequence has completed
- `rd_idx_i`  in  NRD*IW  read indices, port k at bits [k*IW +: IW]
- `rd_data_o`  out  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN]
- `rd_busy_o`  out  NRD  scoreboard busy flag for each read index
- `wr_en_i`  in  NWR  active-high write enables
- `wr_idx_i`  in  NWR*IW  write indices
- `wr_data_i`  in  NWR*XLEN  write data
- `alloc_en_i`  in  1  active-high; marks `alloc_idx_i` as having a pending producer
- `alloc_idx_i`  in  IW  register to allocate

## Operation
- **States:** CLEAR and RUN. `rst` forces CLEAR, sets the clear counter to 1 and zeroes all busy bits.
- **CLEAR state:**
  - Each clock edge writes 0 to `regs[cnt]` and increments `cnt`.
  - After the edge that writes register NREGS-1, the state moves to RUN.
  - `wr_en_i` and `alloc_en_i` are ignored.
  - `rd_data_o` reads 0 and `rd_busy_o` reads 0 on every port.
- **RUN state, writes:**
  - Each enabled write port with a nonzero index updates `regs[idx]` and clears `busy[idx]`.
  - If several ports target the same index, the highest-numbered port wins.
- **RUN state, allocation:**
  - `alloc_en_i` with a nonzero index sets `busy[idx]`.
  - If an allocate and a write hit the same index in the same cycle, the allocate wins: the data is written and busy stays set.
- **Register 0:** writes and allocates to index 0 are dropped. Reads of index 0 return 0 with busy 0.
- **Read path (combinational):**
  - `rd_data_o[k]` is the highest-numbered enabled write port whose index matches `rd_idx_i[k]` (bypass). If none matches, it is `regs[rd_idx_i[k]]`.
  - `rd_busy_o[k]` is `busy[idx]`, forced to 0 when a same-cycle write to that index exists and no same-cycle allocate to it exists.
- **Reset mid-operation:** `rst` at any time, including during CLEAR, restarts the clear from register 1. Register contents are not otherwise reset.

## Timing
- **Reset values:** `ready_o`=0, all `rd_busy_o`=0, all `rd_data_o`=0 (the CLEAR state forces them).
- **Clear length:** `ready_o` rises after exactly NREGS-1 rising edges following `rst` deassertion. For the defaults that is 31 edges. It then stays high until the next `rst`.
- **Write latency:** a write is visible through the bypass in the same cycle and from `regs` after the next edge.
- **Scoreboard latency:** allocate and release take effect on the edge. Reads in the allocating cycle still show the old busy value.
- **Counter width:** the counter is IW bits and must not wrap. The exit is decoded on `cnt == NREGS-1`.

## Structure
- Add `XLEN`/`NREGS` defaults, the CLEAR/RUN state encoding and the index width macro to the shared `defines.v`, next to `REG_IDX`/`DATA_LEN`.
- One natural sub-module: `regfile_clear_seq`. It holds the FSM and counter and outputs `clr_we`, `clr_idx` and `ready`.
- The write-priority and bypass muxes are generate loops inside `regfile_sb`.

## Test plan
- **Clear:** deassert `rst` with default parameters → `ready_o` is 0 for 31 edges, then 1. Reads of registers 1..31 all return 0x0000_0000, busy 0.
- **Bypass and priority:** in RUN, port 0 writes x5=0x1111_1111 and port 1 writes x5=0x2222_2222 in the same cycle. Read x5 → 0x2222_2222 in that cycle and after the edge.
- **Register 0:** write x0=0xDEAD_BEEF and allocate x0 → reads of x0 return 0 with busy 0.
- **Scoreboard:**
  - Allocate x7 → `rd_busy_o` reads 1 from the next cycle.
  - Write x7=0x42 → busy reads 0 in the same cycle, data 0x42.
  - Allocate and write x7 in the same cycle → busy stays 1 after the edge.
- **Mid-clear reset:** assert `rst` 10 edges into CLEAR after x3 held 0x55 → `ready_o` 0, busy cleared. After release, 31 more edges to ready, and x3 reads 0.
- **Parametrisation:** NREGS=16, NRD=3, NWR=1 → ready after 15 edges. Three simultaneous reads of x2, x9 and x15 each return their written values.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_sb_pkg : shared defaults and clear-sequencer state encoding (rev 1.0)
// ----------------------------------------------------------------------------
package regfile_sb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } seq_state_t;

  function automatic int idx_width(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_clear_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_clear_seq : post-reset sequencer zeroing registers 1..NREGS-1 (rev 1.0)
// ----------------------------------------------------------------------------
module regfile_clear_seq
  import regfile_sb_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int IW    = idx_width(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          clr_we,
  output logic [IW-1:0] clr_idx,
  output logic          ready
);

  seq_state_t    state;
  logic [IW-1:0] cnt;

  // The counter parks on the last index instead of wrapping back to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= IW'(1);
      ready <= 1'b0;
    end else if (state == ST_CLEAR) begin
      if (cnt == IW'(NREGS - 1)) begin
        state <= ST_RUN;
        ready <= 1'b1;
      end else begin
        cnt <= cnt + IW'(1);
      end
    end
  end

  assign clr_we  = (state == ST_CLEAR);
  assign clr_idx = cnt;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_sb : multi-port register file with bypass, zero x0 and scoreboard (rev 1.0)
// ----------------------------------------------------------------------------
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int IW    = idx_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready_o,
  input  logic [NRD*IW-1:0]   rd_idx_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*IW-1:0]   wr_idx_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                alloc_en_i,
  input  logic [IW-1:0]       alloc_idx_i
);

  logic          clr_we;
  logic [IW-1:0] clr_idx;
  logic          run;

  regfile_clear_seq #(.NREGS(NREGS)) u_clear_seq (
    .clk     (clk),
    .rst     (rst),
    .clr_we  (clr_we),
    .clr_idx (clr_idx),
    .ready   (run)
  );

  assign ready_o = run;

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign regs[r] = '0;
      assign busy[r] = 1'b0;
    end else begin : g_live
      logic            we;
      logic [XLEN-1:0] wd;
      logic            alloc_hit;
      logic [XLEN-1:0] q;
      logic            b;

      // Ascending scan: the highest-numbered matching port wins.
      always_comb begin
        we = 1'b0;
        wd = '0;
        for (int p = 0; p < NWR; p++) begin
          if (wr_en_i[p] && (wr_idx_i[p*IW +: IW] == IW'(r))) begin
            we = 1'b1;
            wd = wr_data_i[p*XLEN +: XLEN];
          end
        end
      end

      assign alloc_hit = alloc_en_i && (alloc_idx_i == IW'(r));

      always_ff @(posedge clk) begin
        if (clr_we && (clr_idx == IW'(r))) begin
          q <= '0;
        end else if (run && we) begin
          q <= wd;
        end
      end

      // A same-cycle allocate overrides the release from a write.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          b <= 1'b0;
        end else if (run) begin
          if (alloc_hit) begin
            b <= 1'b1;
          end else if (we) begin
            b <= 1'b0;
          end
        end
      end

      assign regs[r] = q;
      assign busy[r] = b;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [IW-1:0]   idx;
    logic            bp_hit;
    logic [XLEN-1:0] bp_data;
    logic            al_hit;
    logic [XLEN-1:0] data;
    logic            bsy;

    assign idx = rd_idx_i[k*IW +: IW];

    always_comb begin
      bp_hit  = 1'b0;
      bp_data = '0;
      for (int p = 0; p < NWR; p++) begin
        if (wr_en_i[p] && (wr_idx_i[p*IW +: IW] == idx)) begin
          bp_hit  = 1'b1;
          bp_data = wr_data_i[p*XLEN +: XLEN];
        end
      end
    end

    assign al_hit = alloc_en_i && (alloc_idx_i == idx);

    always_comb begin
      data = '0;
      bsy  = 1'b0;
      if (run && (idx != '0)) begin
        data = bp_hit ? bp_data : regs[idx];
        bsy  = busy[idx] & ~(bp_hit & ~al_hit);
      end
    end

    assign rd_data_o[k*XLEN +: XLEN] = data;
    assign rd_busy_o[k]              = bsy;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regfile_sb : randomized scoreboard bench for regfile_sb (rev 1.0)
// ----------------------------------------------------------------------------
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready;
  logic [9:0]  rd_idx = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_idx = '0;
  logic [63:0] wr_data = '0;
  logic        alloc_en = 1'b0;
  logic [4:0]  alloc_idx = '0;

  logic        rst2 = 1'b1;
  logic        ready2;
  logic [11:0] rd_idx2 = '0;
  logic [95:0] rd_data2;
  logic [2:0]  rd_busy2;
  logic [0:0]  wr_en2 = '0;
  logic [3:0]  wr_idx2 = '0;
  logic [31:0] wr_data2 = '0;
  logic        alloc_en2 = 1'b0;
  logic [3:0]  alloc_idx2 = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst(rst), .ready_o(ready),
    .rd_idx_i(rd_idx), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data),
    .alloc_en_i(alloc_en), .alloc_idx_i(alloc_idx)
  );

  regfile_sb #(.XLEN(32), .NREGS(16), .NRD(3), .NWR(1)) dut16 (
    .clk(clk), .rst(rst2), .ready_o(ready2),
    .rd_idx_i(rd_idx2), .rd_data_o(rd_data2), .rd_busy_o(rd_busy2),
    .wr_en_i(wr_en2), .wr_idx_i(wr_idx2), .wr_data_i(wr_data2),
    .alloc_en_i(alloc_en2), .alloc_idx_i(alloc_idx2)
  );

  // Reference model: architectural state plus edges elapsed since reset release.
  logic [31:0] m_reg  [32];
  logic        m_busy [32];
  logic        m_ready = 1'b0;
  int          m_clr   = 0;

  typedef struct {
    string       name;
    logic        rdy;
    logic [63:0] data;
    logic [1:0]  busy;
  } exp_t;
  exp_t sbq[$];

  function automatic void model_read(input logic [4:0] idx, output logic [31:0] d,
                                     output logic b);
    logic hit;
    d = '0;
    b = 1'b0;
    if (!m_ready || idx == 5'd0) return;
    hit = 1'b0;
    d   = m_reg[idx];
    for (int p = 0; p < 2; p++)
      if (wr_en[p] && wr_idx[p*5 +: 5] == idx) begin
        hit = 1'b1;
        d   = wr_data[p*32 +: 32];
      end
    b = m_busy[idx] && !(hit && !(alloc_en && alloc_idx == idx));
  endfunction

  function automatic void model_edge();
    logic [4:0] w;
    if (!m_ready) begin
      m_clr++;
      m_reg[m_clr] = '0;
      if (m_clr == 31) m_ready = 1'b1;
    end else begin
      for (int p = 0; p < 2; p++) begin
        w = wr_idx[p*5 +: 5];
        if (wr_en[p] && w != 5'd0) begin
          m_reg[w]  = wr_data[p*32 +: 32];
          m_busy[w] = 1'b0;
        end
      end
      if (alloc_en && alloc_idx != 5'd0) m_busy[alloc_idx] = 1'b1;
    end
  endfunction

  // Inputs already applied: record expectation, advance one edge, update model.
  task automatic cycle(input string nm);
    exp_t        e;
    logic [31:0] d;
    logic        b;
    e.name = nm;
    e.rdy  = m_ready;
    for (int k = 0; k < 2; k++) begin
      model_read(rd_idx[k*5 +: 5], d, b);
      e.data[k*32 +: 32] = d;
      e.busy[k]          = b;
    end
    sbq.push_back(e);
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en    = '0;
    alloc_en = 1'b0;
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < 2; k++) begin
      rd_idx[k*5 +: 5] = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      wr_idx[k*5 +: 5] = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
    end
    wr_en     = 2'($urandom);
    wr_data   = {$urandom, $urandom};
    alloc_en  = ($urandom_range(0, 2) == 0);
    alloc_idx = 5'($urandom_range(0, 7));
  endtask

  task automatic apply_reset(input int hold);
    rst     = 1'b1;
    m_ready = 1'b0;
    m_clr   = 0;
    for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    for (int i = 0; i < hold; i++) begin
      rand_inputs();
      cycle("reset");
    end
    rst = 1'b0;
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      tests++;
      if (ready !== e.rdy || rd_data !== e.data || rd_busy !== e.busy) begin
        fails++;
        $display("FAIL %s: got ready=%0b data=%h busy=%b, expected ready=%0b data=%h busy=%b",
                 e.name, ready, rd_data, rd_busy, e.rdy, e.data, e.busy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] v2, v9, v15;

    for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    @(posedge clk); #1;
    apply_reset(3);

    // Clear phase: writes and allocates must be ignored, reads forced to zero.
    for (int i = 0; i < 31; i++) begin rand_inputs(); cycle("clear"); end
    idle();
    for (int r = 1; r < 32; r += 2) begin
      rd_idx = {5'(r + 1), 5'(r)};
      cycle("cleared_regs");
    end

    // Bypass and write-port priority on x5.
    wr_en   = 2'b11;
    wr_idx  = {5'd5, 5'd5};
    wr_data = {32'h2222_2222, 32'h1111_1111};
    rd_idx  = {5'd5, 5'd5};
    cycle("bypass_x5");
    idle();
    cycle("stored_x5");

    // Register 0 drops writes and allocates.
    wr_en     = 2'b01;
    wr_idx    = {5'd0, 5'd0};
    wr_data   = {32'h0, 32'hDEAD_BEEF};
    alloc_en  = 1'b1;
    alloc_idx = 5'd0;
    rd_idx    = {5'd0, 5'd0};
    cycle("x0_write");
    idle();
    cycle("x0_after");

    // Scoreboard on x7.
    rd_idx    = {5'd0, 5'd7};
    alloc_en  = 1'b1;
    alloc_idx = 5'd7;
    cycle("alloc_x7");
    idle();
    cycle("busy_x7");
    wr_en   = 2'b01;
    wr_idx  = {5'd0, 5'd7};
    wr_data = {32'h0, 32'h42};
    cycle("release_x7");
    alloc_en  = 1'b1;
    alloc_idx = 5'd7;
    wr_en     = 2'b10;
    wr_idx    = {5'd7, 5'd0};
    wr_data   = {32'h77, 32'h0};
    cycle("alloc_write_x7");
    idle();
    cycle("alloc_wins_x7");

    for (int i = 0; i < 400; i++) begin rand_inputs(); cycle("random"); end

    // Reset 10 edges into a clear after x3 held data and was busy.
    idle();
    wr_en     = 2'b01;
    wr_idx    = {5'd0, 5'd3};
    wr_data   = {32'h0, 32'h55};
    alloc_en  = 1'b1;
    alloc_idx = 5'd3;
    rd_idx    = {5'd3, 5'd3};
    cycle("x3_write");
    idle();
    cycle("x3_held");
    apply_reset(2);
    for (int i = 0; i < 10; i++) begin rand_inputs(); cycle("partial_clear"); end
    apply_reset(2);
    for (int i = 0; i < 31; i++) begin rand_inputs(); cycle("reclear"); end
    idle();
    rd_idx = {5'd3, 5'd3};
    cycle("x3_zero");
    for (int i = 0; i < 100; i++) begin rand_inputs(); cycle("random2"); end
    idle();

    // Second configuration: 16 registers, 3 read ports, 1 write port.
    rst2 = 1'b1;
    @(posedge clk); #1;
    check("p16_reset_ready", 128'(ready2), 128'd0);
    check("p16_reset_reads", 128'(rd_data2), 128'd0);
    rst2 = 1'b0;
    n = 0;
    while (!ready2 && n < 40) begin @(posedge clk); #1; n++; end
    check("p16_clear_len", 128'(n), 128'd15);
    v2  = $urandom;
    v9  = $urandom;
    v15 = $urandom;
    wr_en2 = 1'b1;
    wr_idx2 = 4'd2;  wr_data2 = v2;  @(posedge clk); #1;
    wr_idx2 = 4'd9;  wr_data2 = v9;  @(posedge clk); #1;
    wr_idx2 = 4'd15; wr_data2 = v15; @(posedge clk); #1;
    wr_en2  = 1'b0;
    rd_idx2 = {4'd15, 4'd9, 4'd2};
    #1;
    check("p16_three_reads", 128'(rd_data2), 128'({v15, v9, v2}));
    check("p16_busy", 128'(rd_busy2), 128'd0);
    check("p16_ready_hold", 128'(ready2), 128'd1);

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drained", 128'(sbq.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
